fp_sum_arbiter: RTL

Round-robin arbiter and sequencer that shares one `comb_fp_summator` instance between `N_REQ` independent requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants one requester at a time and registers the operands into the summator. It then returns the registered sum, status and requester ID on a single response channel with its own valid/ready handshake. It sits between the FPU's client ports and the shared combinational adder, and isolates the adder's long combinational path between two register stages.

---
 rtl/fp_sum_arbiter.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/fp_sum_arbiter.sv
// Round-robin arbiter sharing one combinational FP32 adder between requesters.
// Operands and results are registered on both sides of the adder path.
package fp_sum_pkg;
    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] mant;
    } float_point_num;

    typedef enum logic [1:0] {
        OK_state   = 2'd0,
        ZERO_res   = 2'd1,
        NAN_or_INF = 2'd2
    } fp_status_t;
endpackage

module comb_fp_summator
    import fp_sum_pkg::*;
(
    input  logic           vld_i,
    input  float_point_num a_i,
    input  float_point_num b_i,
    output float_point_num answer_o,
    output fp_status_t     answer_status_o
);
    float_point_num big, sml;
    logic [7:0]  eb, es, d;
    logic [4:0]  sh;
    logic [26:0] mb, ms, al, n;
    logic [58:0] wide;
    logic [27:0] s;
    logic [24:0] m;
    logic [9:0]  e;
    logic        inc, a_nan, b_nan, inf_cancel;

    always_comb begin
        answer_o        = '0;
        answer_status_o = OK_state;
        big = a_i;
        sml = b_i;
        if ({b_i.exp, b_i.mant} > {a_i.exp, a_i.mant}) begin
            big = b_i;
            sml = a_i;
        end
        eb   = (big.exp == 8'd0) ? 8'd1 : big.exp;
        es   = (sml.exp == 8'd0) ? 8'd1 : sml.exp;
        mb   = {big.exp != 8'd0, big.mant, 3'b000};
        ms   = {sml.exp != 8'd0, sml.mant, 3'b000};
        d    = eb - es;
        sh   = (d > 8'd31) ? 5'd31 : d[4:0];
        wide = {ms, 32'd0} >> sh;
        // bits shifted out collapse into a sticky LSB for RNE
        al   = wide[58:32] | {26'd0, |wide[31:0]};
        if (big.sign == sml.sign)
            s = {1'b0, mb} + {1'b0, al};
        else
            s = {1'b0, mb} - {1'b0, al};
        e = {2'b00, eb};
        if (s[27]) begin
            n = s[27:1] | {26'd0, s[0]};
            e = e + 10'd1;
        end else begin
            n = s[26:0];
            for (int i = 0; i < 26; i++) begin
                if (!n[26] && e > 10'd1) begin
                    n = n << 1;
                    e = e - 10'd1;
                end
            end
        end
        inc = n[2] & (n[1] | n[0] | n[3]);
        m   = {1'b0, n[26:3]} + {24'd0, inc};
        if (m[24]) begin
            m = m >> 1;
            e = e + 10'd1;
        end
        a_nan      = (a_i.exp == 8'hFF) && (a_i.mant != 23'd0);
        b_nan      = (b_i.exp == 8'hFF) && (b_i.mant != 23'd0);
        inf_cancel = (a_i.exp == 8'hFF) && (b_i.exp == 8'hFF)
                     && (a_i.sign != b_i.sign);
        if (a_i.exp == 8'hFF || b_i.exp == 8'hFF) begin
            answer_status_o = NAN_or_INF;
            if (a_nan || b_nan || inf_cancel)
                answer_o = 32'h7FC0_0000;
            else
                answer_o = big;
        end else if (s == 28'd0) begin
            answer_status_o = ZERO_res;
            answer_o.sign   = a_i.sign & b_i.sign;
        end else if (e >= 10'd255) begin
            answer_status_o = NAN_or_INF;
            answer_o        = {big.sign, 8'hFF, 23'd0};
        end else begin
            answer_o = {big.sign, m[23] ? e[7:0] : 8'd0, m[22:0]};
        end
        if (!vld_i) begin
            answer_o        = '0;
            answer_status_o = OK_state;
        end
    end
endmodule

module fp_sum_arbiter
    import fp_sum_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [N_REQ-1:0]           req_vld_i,
    input  float_point_num [N_REQ-1:0] req_a_i,
    input  float_point_num [N_REQ-1:0] req_b_i,
    output logic [N_REQ-1:0]           req_rdy_o,
    output logic                       resp_vld_o,
    input  logic                       resp_rdy_i,
    output logic [ID_W-1:0]            resp_id_o,
    output float_point_num             resp_sum_o,
    output fp_status_t                 resp_status_o,
    output logic                       busy_o,
    output logic [15:0]                ops_cnt_o
);
    typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;

    state_t          state;
    logic [ID_W-1:0] rr_ptr, gnt_id, next_ptr, id_q, cand;
    logic [ID_W:0]   cand_w;
    logic            gnt_any;
    float_point_num  op_a, op_b, sum;
    fp_status_t      status;
    logic [15:0]     ops_cnt_q;

    // iterate downwards so the lowest offset from rr_ptr wins
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = '0;
        cand_w  = '0;
        cand    = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            cand_w = {1'b0, rr_ptr} + (ID_W + 1)'(i);
            if (cand_w >= (ID_W + 1)'(N_REQ))
                cand_w = cand_w - (ID_W + 1)'(N_REQ);
            cand = cand_w[ID_W-1:0];
            if (req_vld_i[cand]) begin
                gnt_any = 1'b1;
                gnt_id  = cand;
            end
        end
        next_ptr = (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;
    end

    always_comb begin
        req_rdy_o = '0;
        if (state == IDLE && gnt_any && !rst_i)
            req_rdy_o[gnt_id] = 1'b1;
    end

    comb_fp_summator u_sum (
        .vld_i           (state == CALC),
        .a_i             (op_a),
        .b_i             (op_b),
        .answer_o        (sum),
        .answer_status_o (status)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            id_q          <= '0;
            op_a          <= '0;
            op_b          <= '0;
            resp_vld_o    <= 1'b0;
            resp_id_o     <= '0;
            resp_sum_o    <= '0;
            resp_status_o <= OK_state;
            ops_cnt_q     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (gnt_any) begin
                        op_a   <= req_a_i[gnt_id];
                        op_b   <= req_b_i[gnt_id];
                        id_q   <= gnt_id;
                        rr_ptr <= next_ptr;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    resp_sum_o    <= sum;
                    resp_status_o <= status;
                    resp_id_o     <= id_q;
                    resp_vld_o    <= 1'b1;
                    state         <= HOLD;
                end
                HOLD: begin
                    if (resp_rdy_i) begin
                        resp_vld_o <= 1'b0;
                        ops_cnt_q  <= ops_cnt_q + 16'd1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy_o    = (state != IDLE);
    assign ops_cnt_o = ops_cnt_q;
endmodule
